// File: rtl/wb_pkg.sv
// Shared opcode map, ALU slot count and FSM state encoding for the write-back stage.
package wb_pkg;

  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_NEG  = 6;
  localparam int OP_MUL  = 7;
  localparam int OP_DIV  = 8;
  localparam int OP_OR   = 9;
  localparam int OP_XOR  = 10;
  localparam int OP_NAND = 11;
  localparam int OP_NOR  = 12;
  localparam int OP_XNOR = 13;
  localparam int OP_NOT  = 14;
  localparam int OP_LLSH = 15;
  localparam int OP_LRSH = 16;

  localparam int OP_ALU_FIRST = OP_ADD;
  localparam int OP_ALU_LAST  = OP_LRSH;
  localparam int NUM_OPS      = OP_ALU_LAST - OP_ALU_FIRST + 1;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_HI   = 1'b1;

endpackage

// File: rtl/wb_result_mux.sv
// Picks the ALU result slot that belongs to the opcode and flags whether the opcode is an ALU op.
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 6,
  parameter int N_SLOTS  = wb_pkg::NUM_OPS
) (
  input  logic [OPC_W-1:0]          opcode_i,
  input  logic [N_SLOTS*DATA_W-1:0] resBus_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      isAlu_o
);

  always_comb begin
    data_o  = '0;
    isAlu_o = (opcode_i >= OPC_W'(OP_ALU_FIRST)) && (opcode_i <= OPC_W'(OP_ALU_LAST));
    for (int k = 0; k < N_SLOTS; k++) begin
      if (opcode_i == OPC_W'(OP_ALU_FIRST + k)) begin
        data_o = resBus_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage driving one register-file write port from the packed ALU result bus.
// Define WB_MUL_HI_EN to commit the MUL high half as a second write to rd_addr+1.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 6,
  parameter int REG_AW  = 3,
  parameter int NUM_OPS = wb_pkg::NUM_OPS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPC_W-1:0]          opcode,
  input  logic [REG_AW-1:0]         rd_addr,
  input  logic [NUM_OPS*DATA_W-1:0] res_bus,
  input  logic [DATA_W-1:0]         mul_hi,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      zero_flag,
  output logic [15:0]               retire_cnt
);

  logic [DATA_W-1:0] selData;
  logic              isAlu;
  logic              accept;

  logic              rfWe_q,    rfWe_d;
  logic [REG_AW-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
  logic              zero_q,    zero_d;
  logic [15:0]       cnt_q,     cnt_d;

  wb_result_mux #(
    .DATA_W  (DATA_W),
    .OPC_W   (OPC_W),
    .N_SLOTS (NUM_OPS)
  ) u_mux (
    .opcode_i (opcode),
    .resBus_i (res_bus),
    .data_o   (selData),
    .isAlu_o  (isAlu)
  );

`ifdef WB_MUL_HI_EN
  state_t            state_q,  state_d;
  logic [REG_AW-1:0] hiAddr_q, hiAddr_d;
  logic [DATA_W-1:0] hiData_q, hiData_d;

  assign in_ready = !rst && (state_q == S_IDLE);
`else
  logic [DATA_W-1:0] unused_mul_hi;

  assign unused_mul_hi = mul_hi;
  assign in_ready      = !rst;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    rfWe_d    = 1'b0;
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
`ifdef WB_MUL_HI_EN
    state_d   = S_IDLE;
    hiAddr_d  = hiAddr_q;
    hiData_d  = hiData_q;
    // The high half was captured with the MUL transfer; S_HI only replays it.
    if (state_q == S_HI) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = hiAddr_q;
      rfWdata_d = hiData_q;
    end else if (accept && isAlu) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = rd_addr;
      rfWdata_d = selData;
      if (opcode == OPC_W'(OP_MUL)) begin
        state_d  = S_HI;
        hiAddr_d = rd_addr + REG_AW'(1);
        hiData_d = mul_hi;
      end
    end
`else
    if (accept && isAlu) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = rd_addr;
      rfWdata_d = selData;
    end
`endif
    if (rfWe_d) begin
      zero_d = (rfWdata_d == '0);
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef WB_MUL_HI_EN
      state_q   <= S_IDLE;
      hiAddr_q  <= '0;
      hiData_q  <= '0;
`endif
    end else begin
      rfWe_q    <= rfWe_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
      zero_q    <= zero_d;
      cnt_q     <= cnt_d;
`ifdef WB_MUL_HI_EN
      state_q   <= state_d;
      hiAddr_q  <= hiAddr_d;
      hiData_q  <= hiData_d;
`endif
    end
  end

  assign rf_we      = rfWe_q;
  assign rf_waddr   = rfWaddr_q;
  assign rf_wdata   = rfWdata_q;
  assign zero_flag  = zero_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expected values are hand-computed per step.
module tb_wb_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [2:0]    rd_addr;
  logic [207:0]  res_bus;
  logic [15:0]   mul_hi;
  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [15:0]   rf_wdata;
  logic          zero_flag;
  logic [15:0]   retire_cnt;

  int checks   = 0;
  int failures = 0;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rd_addr    (rd_addr),
    .res_bus    (res_bus),
    .mul_hi     (mul_hi),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .zero_flag  (zero_flag),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Every slot gets a distinct background value so a wrong slot select shows up.
  task automatic applyStimulus(input logic valid, input logic [5:0] opc, input logic [2:0] rd,
                               input logic [15:0] data, input logic [15:0] hi);
    for (int k = 0; k < 13; k++) res_bus[k*16 +: 16] = 16'hA000 + 16'(k);
    if (opc >= 6'd4 && opc <= 6'd16) res_bus[(int'(opc) - 4)*16 +: 16] = data;
    in_valid = valid;
    opcode   = opc;
    rd_addr  = rd;
    mul_hi   = hi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic we, input logic [2:0] addr,
                             input logic [15:0] data, input logic zf, input logic [15:0] cnt,
                             input logic rdy);
    chk({tag, ".we"},    32'(rf_we),      32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr),   32'(addr));
    chk({tag, ".wdata"}, 32'(rf_wdata),   32'(data));
    chk({tag, ".zero"},  32'(zero_flag),  32'(zf));
    chk({tag, ".cnt"},   32'(retire_cnt), 32'(cnt));
    chk({tag, ".ready"}, 32'(in_ready),   32'(rdy));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 3'd0, 16'h0000, 16'h0000);
    step();
    step();
    checkOutput("reset", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0, 1'b0);

    rst = 1'b0;
    applyStimulus(1'b1, 6'd4, 3'd3, 16'h1234, 16'h0000);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    step();
    checkOutput("add", 1'b1, 3'd3, 16'h1234, 1'b0, 16'd1, 1'b1);

    applyStimulus(1'b1, 6'd5, 3'd1, 16'h0000, 16'h0000);
    step();
    checkOutput("sub_zero", 1'b1, 3'd1, 16'h0000, 1'b1, 16'd2, 1'b1);

    applyStimulus(1'b1, 6'd10, 3'd2, 16'h00FF, 16'h0000);
    step();
    checkOutput("xor", 1'b1, 3'd2, 16'h00FF, 1'b0, 16'd3, 1'b1);

    applyStimulus(1'b0, 6'd9, 3'd6, 16'h7777, 16'h0000);
    step();
    checkOutput("idle_hold", 1'b0, 3'd2, 16'h00FF, 1'b0, 16'd3, 1'b1);

    applyStimulus(1'b1, 6'd7, 3'd7, 16'hBEEF, 16'h0001);
    step();
`ifdef WB_MUL_HI_EN
    checkOutput("mul_lo", 1'b1, 3'd7, 16'hBEEF, 1'b0, 16'd4, 1'b0);
    // OR is offered while the high half is pending and must wait; mul_hi changes underneath.
    applyStimulus(1'b1, 6'd9, 3'd5, 16'h5555, 16'hFFFF);
    step();
    checkOutput("mul_hi_wrap", 1'b1, 3'd0, 16'h0001, 1'b0, 16'd5, 1'b1);
    step();
    checkOutput("or_after_mul", 1'b1, 3'd5, 16'h5555, 1'b0, 16'd6, 1'b1);
`else
    checkOutput("mul_lo", 1'b1, 3'd7, 16'hBEEF, 1'b0, 16'd4, 1'b1);
    applyStimulus(1'b1, 6'd9, 3'd5, 16'h5555, 16'hFFFF);
    step();
    checkOutput("or_after_mul", 1'b1, 3'd5, 16'h5555, 1'b0, 16'd5, 1'b1);
`endif

    applyStimulus(1'b1, 6'd2, 3'd4, 16'h9999, 16'h0000);
    step();
`ifdef WB_MUL_HI_EN
    checkOutput("load_ignored", 1'b0, 3'd5, 16'h5555, 1'b0, 16'd6, 1'b1);
`else
    checkOutput("load_ignored", 1'b0, 3'd5, 16'h5555, 1'b0, 16'd5, 1'b1);
`endif

    applyStimulus(1'b1, 6'd16, 3'd6, 16'h0000, 16'h0000);
    step();
`ifdef WB_MUL_HI_EN
    checkOutput("lrsh_last_slot", 1'b1, 3'd6, 16'h0000, 1'b1, 16'd7, 1'b1);
`else
    checkOutput("lrsh_last_slot", 1'b1, 3'd6, 16'h0000, 1'b1, 16'd6, 1'b1);
`endif

    applyStimulus(1'b1, 6'd17, 3'd3, 16'h4321, 16'h0000);
    step();
`ifdef WB_MUL_HI_EN
    checkOutput("op17_ignored", 1'b0, 3'd6, 16'h0000, 1'b1, 16'd7, 1'b1);
`else
    checkOutput("op17_ignored", 1'b0, 3'd6, 16'h0000, 1'b1, 16'd6, 1'b1);
`endif

    applyStimulus(1'b1, 6'd7, 3'd1, 16'h1111, 16'h2222);
    step();
`ifdef WB_MUL_HI_EN
    checkOutput("mul2_lo", 1'b1, 3'd1, 16'h1111, 1'b0, 16'd8, 1'b0);
`else
    checkOutput("mul2_lo", 1'b1, 3'd1, 16'h1111, 1'b0, 16'd7, 1'b1);
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 3'd0, 16'h0000, 16'h0000);
    step();
    checkOutput("reset_in_hi", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("no_late_hi", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
